pipeline_skid_reg: RTL



---
 rtl/pipeline_skid_reg_pkg.sv | 20 ++
 rtl/pipeline_skid_reg.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipeline_skid_reg_pkg.sv
// rtl/pipeline_skid_reg_pkg.sv - shared occupancy encodings and stage payload widths
package pipeline_skid_reg_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  localparam int IF_ID_WIDTH        = 64;
  localparam int ID_EX_WIDTH        = 128;
  localparam int EX_MEM_WIDTH       = 112;
  localparam int MEM_WB_WIDTH       = 72;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  function automatic logic [1:0] occ_of(input logic main_valid, input logic skid_valid);
    return {1'b0, main_valid} + {1'b0, skid_valid};
  endfunction

endpackage

// File: rtl/pipeline_skid_reg.sv
// rtl/pipeline_skid_reg.sv - elastic two-entry pipeline register with flush and stall counter
module pipeline_skid_reg
  import pipeline_skid_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = IF_ID_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = {DATA_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [1:0]            OCCUPANCY,
  output logic [CNT_WIDTH-1:0]  STALL_CNT
);

  occ_state_e            state;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  in_ready_q;
  logic [CNT_WIDTH-1:0]  stall_q;
  logic                  main_valid;
  logic                  skid_valid;
  logic                  in_fire;
  logic                  out_fire;

  assign main_valid = (state != OCC_EMPTY);
  assign skid_valid = (state == OCC_FULL);
  assign in_fire    = IN_VALID & in_ready_q;
  assign out_fire   = main_valid & OUT_READY;

  // main_data is forced to BUBBLE_DATA whenever the main entry empties, so OUT_DATA is a plain flop
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = main_valid;
  assign OUT_DATA  = main_data;
  assign OCCUPANCY = occ_of(main_valid, skid_valid);
  assign STALL_CNT = stall_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= OCC_EMPTY;
      main_data  <= BUBBLE_DATA;
      skid_data  <= BUBBLE_DATA;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      if (main_valid && !OUT_READY && stall_q != {CNT_WIDTH{1'b1}}) begin
        stall_q <= stall_q + 1'b1;
      end

      if (FLUSH) begin
        state      <= OCC_EMPTY;
        main_data  <= BUBBLE_DATA;
        skid_data  <= BUBBLE_DATA;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          OCC_EMPTY: begin
            if (in_fire) begin
              main_data <= IN_DATA;
              state     <= OCC_ONE;
            end
          end
          OCC_ONE: begin
            if (in_fire && !out_fire) begin
              skid_data  <= IN_DATA;
              in_ready_q <= 1'b0;
              state      <= OCC_FULL;
            end else if (in_fire && out_fire) begin
              main_data <= IN_DATA;
            end else if (out_fire) begin
              main_data <= BUBBLE_DATA;
              state     <= OCC_EMPTY;
            end
          end
          OCC_FULL: begin
            if (out_fire) begin
              main_data  <= skid_data;
              skid_data  <= BUBBLE_DATA;
              in_ready_q <= 1'b1;
              state      <= OCC_ONE;
            end
          end
          default: begin
            main_data  <= BUBBLE_DATA;
            skid_data  <= BUBBLE_DATA;
            in_ready_q <= 1'b1;
            state      <= OCC_EMPTY;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      assert (OCCUPANCY != 2'd3);
      assert (in_ready_q == !skid_valid);
    end
  end

endmodule
